rnn_seq_ctrl: RTL and testbench

Bus-master sequencer that drives the rnn core's 32-bit slave port on its own, so the host CPU does not have to. It accepts a stream of character indices. For each character it fetches the 4-entry embedding from the embedding RAM, writes it to the core, starts a recurrent step, and polls until the step completes. After the last character it triggers the dense layer, reads the 16-bit result and presents it on a valid/ready output. It sits between the host-side character FIFO and the rnn slave port. Weight, bias and dense loads stay host-driven and happen before the sequence starts.

---
 rtl/rnn_pkg.sv | 37 +++
 rtl/rnn_seq_ctrl_if.sv | 40 ++++
 rtl/rnn_poll_timer.sv | 29 ++
 rtl/rnn_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rnn_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rnn_pkg.sv
// Shared constants and state encoding for the rnn sequencer: core register map,
// status/result bit positions and the sequencer state type.
package rnn_pkg;

  localparam logic [2:0] RNN_ADDR_START = 3'd0;
  localparam logic [2:0] RNN_ADDR_EMB   = 3'd1;
  localparam logic [2:0] RNN_ADDR_W     = 3'd2;
  localparam logic [2:0] RNN_ADDR_R     = 3'd3;
  localparam logic [2:0] RNN_ADDR_RB    = 3'd4;
  localparam logic [2:0] RNN_ADDR_D     = 3'd5;
  localparam logic [2:0] RNN_ADDR_DB    = 3'd6;
  localparam logic [2:0] RNN_ADDR_DENSE = 3'd7;

  localparam int STATUS_IDLE_BIT = 0;
  localparam int RES_VALID_BIT   = 31;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WR_EMB,
    S_KICK,
    S_POLL,
    S_CHK,
    S_WAIT_CHAR,
    S_DENSE,
    S_RPOLL,
    S_RCHK,
    S_OUT,
    S_ERR
  } seq_state_t;

  // Weight/bias/dense loads belong to the host; the sequencer never touches them.
  function automatic logic is_host_addr(input logic [2:0] a);
    return a inside {RNN_ADDR_W, RNN_ADDR_R, RNN_ADDR_RB, RNN_ADDR_D, RNN_ADDR_DB};
  endfunction

endpackage

// File: rtl/rnn_seq_ctrl_if.sv
// Bundle of the sequencer's character stream, embedding RAM port, core bus and
// result handshake. master = sequencer side, slave = environment side.
interface rnn_seq_ctrl_if #(
  parameter int CHAR_W  = 8,
  parameter int EMB_DIM = 4
);
  localparam int EMB_AW = CHAR_W + $clog2(EMB_DIM);

  logic              char_valid;
  logic              char_ready;
  logic [CHAR_W-1:0] char_idx;
  logic              char_last;

  logic              emb_rd;
  logic [EMB_AW-1:0] emb_addr;
  logic [15:0]       emb_rdata;

  logic              rnn_read;
  logic              rnn_write;
  logic [2:0]        rnn_addr;
  logic [31:0]       rnn_wdata;
  logic [31:0]       rnn_rdata;

  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_data;

  modport master (
    input  char_valid, char_idx, char_last, emb_rdata, rnn_rdata, res_ready,
    output char_ready, emb_rd, emb_addr, rnn_read, rnn_write, rnn_addr, rnn_wdata,
           res_valid, res_data
  );

  modport slave (
    output char_valid, char_idx, char_last, emb_rdata, rnn_rdata, res_ready,
    input  char_ready, emb_rd, emb_addr, rnn_read, rnn_write, rnn_addr, rnn_wdata,
           res_valid, res_data
  );

endinterface

// File: rtl/rnn_poll_timer.sv
// Counts unsuccessful status polls; expire_o flags that the next increment would
// reach POLL_MAX, so the caller can give up instead of polling again.
module rnn_poll_timer #(
  parameter int POLL_MAX = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);
  localparam int CNT_W = $clog2(POLL_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == CNT_W'(POLL_MAX - 1));

endmodule

// File: rtl/rnn_seq_ctrl.sv
// Bus-master sequencer: streams character embeddings into the rnn core, runs one
// recurrent step per character, then fires the dense layer and returns its result.
module rnn_seq_ctrl
  import rnn_pkg::*;
#(
  parameter int CHAR_W   = 8,
  parameter int EMB_DIM  = 4,
  parameter int POLL_MAX = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 abort,
  rnn_seq_ctrl_if.master       bus,
  output logic                 busy,
  output logic                 err,
  output logic [15:0]          seq_len
);
  localparam int WORD_W = $clog2(EMB_DIM);

  seq_state_t        state_q, state_d;
  logic [CHAR_W-1:0] idx_q, idx_d;
  logic              last_q, last_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [15:0]       seq_len_q, seq_len_d;
  logic [15:0]       res_q, res_d;
  logic              err_q, err_d;
  logic              rdy_q, rdy_d;

  logic tmr_clr, tmr_inc, tmr_expire;
  logic char_hs, status_idle, res_vld;
  logic unused_rdata;

  assign char_hs      = bus.char_valid & rdy_q;
  assign status_idle  = bus.rnn_rdata[STATUS_IDLE_BIT];
  assign res_vld      = bus.rnn_rdata[RES_VALID_BIT];
  assign unused_rdata = &{1'b0, bus.rnn_rdata[30:16]};

  rnn_poll_timer #(.POLL_MAX(POLL_MAX)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .inc_i    (tmr_inc),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    word_d    = word_q;
    seq_len_d = seq_len_q;
    res_d     = res_q;
    err_d     = err_q;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (char_hs) begin
          idx_d     = bus.char_idx;
          last_d    = bus.char_last;
          word_d    = '0;
          seq_len_d = '0;
          err_d     = 1'b0;
          state_d   = S_FETCH;
        end
        S_FETCH:  state_d = S_WR_EMB;
        S_WR_EMB: begin
          if (word_q == WORD_W'(EMB_DIM - 1)) begin
            state_d = S_KICK;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = S_FETCH;
          end
        end
        S_KICK: begin
          tmr_clr = 1'b1;
          state_d = S_POLL;
        end
        S_POLL: state_d = S_CHK;
        S_CHK: begin
          if (status_idle) begin
            if (seq_len_q != 16'hFFFF) seq_len_d = seq_len_q + 16'd1;
            state_d = last_q ? S_DENSE : S_WAIT_CHAR;
          end else if (tmr_expire) begin
            state_d = S_ERR;
          end else begin
            tmr_inc = 1'b1;
            state_d = S_POLL;
          end
        end
        // Mid-sequence characters keep seq_len and err running.
        S_WAIT_CHAR: if (char_hs) begin
          idx_d   = bus.char_idx;
          last_d  = bus.char_last;
          word_d  = '0;
          state_d = S_FETCH;
        end
        S_DENSE: begin
          tmr_clr = 1'b1;
          state_d = S_RPOLL;
        end
        S_RPOLL: state_d = S_RCHK;
        S_RCHK: begin
          if (res_vld) begin
            res_d   = bus.rnn_rdata[15:0];
            state_d = S_OUT;
          end else if (tmr_expire) begin
            state_d = S_ERR;
          end else begin
            tmr_inc = 1'b1;
            state_d = S_RPOLL;
          end
        end
        S_OUT: if (bus.res_ready) state_d = S_IDLE;
        S_ERR: begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // char_ready is registered so it stays low while reset is held.
    rdy_d = (state_d == S_IDLE) || (state_d == S_WAIT_CHAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= 1'b0;
      word_q    <= '0;
      seq_len_q <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      word_q    <= word_d;
      seq_len_q <= seq_len_d;
      res_q     <= res_d;
      err_q     <= err_d;
      rdy_q     <= rdy_d;
    end
  end

  // Bus outputs decode straight from the state so each strobe lives one state.
  always_comb begin
    bus.rnn_addr = RNN_ADDR_START;
    unique case (state_q)
      S_WR_EMB:        bus.rnn_addr = RNN_ADDR_EMB;
      S_DENSE, S_RPOLL: bus.rnn_addr = RNN_ADDR_DENSE;
      default:         bus.rnn_addr = RNN_ADDR_START;
    endcase
  end

  assign bus.char_ready = rdy_q;
  assign bus.emb_rd     = (state_q == S_FETCH);
  assign bus.emb_addr   = {idx_q, word_q};
  assign bus.rnn_write  = (state_q == S_WR_EMB) || (state_q == S_KICK) || (state_q == S_DENSE);
  assign bus.rnn_read   = (state_q == S_POLL) || (state_q == S_RPOLL);
  assign bus.rnn_wdata  = (state_q == S_WR_EMB) ? {16'(word_q), bus.emb_rdata} : 32'd0;
  assign bus.res_valid  = (state_q == S_OUT);
  assign bus.res_data   = res_q;

  assign busy    = (state_q != S_IDLE);
  assign err     = err_q;
  assign seq_len = seq_len_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.rnn_read && bus.rnn_write));
      if (bus.rnn_write) assert (!is_host_addr(bus.rnn_addr));
    end
  end

endmodule

// File: tb/tb_rnn_seq_ctrl.sv
// Directed + randomized bench for rnn_seq_ctrl with an embedding RAM model, a
// core responder and a transaction-level expectation built from the register map.
module tb_rnn_seq_ctrl;
  localparam int CHAR_W   = 8;
  localparam int EMB_DIM  = 4;
  localparam int POLL_MAX = 4;
  localparam int BOUND    = 3000;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic        busy;
  logic        err;
  logic [15:0] seq_len;

  rnn_seq_ctrl_if #(.CHAR_W(CHAR_W), .EMB_DIM(EMB_DIM)) bus ();

  rnn_seq_ctrl #(.CHAR_W(CHAR_W), .EMB_DIM(EMB_DIM), .POLL_MAX(POLL_MAX)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .abort   (abort),
    .bus     (bus),
    .busy    (busy),
    .err     (err),
    .seq_len (seq_len)
  );

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: embedding RAM and a core that reports busy step_busy times per step.
  logic [15:0] emb_mem [0:1023];
  logic [31:0] rnd;
  int          step_busy, dense_busy, polls_left, dpolls_left;
  logic [15:0] res_val;

  always @(posedge clk) rnd <= $urandom;

  always @(posedge clk) if (bus.emb_rd) bus.emb_rdata <= emb_mem[bus.emb_addr];

  always @(posedge clk) begin
    if (bus.rnn_write && bus.rnn_addr == 3'd0) polls_left  <= step_busy;
    if (bus.rnn_write && bus.rnn_addr == 3'd7) dpolls_left <= dense_busy;
    if (bus.rnn_read && bus.rnn_addr == 3'd0) begin
      if (polls_left > 0) begin
        bus.rnn_rdata <= {rnd[31:1], 1'b0};
        polls_left    <= polls_left - 1;
      end else begin
        bus.rnn_rdata <= {rnd[31:1], 1'b1};
      end
    end else if (bus.rnn_read && bus.rnn_addr == 3'd7) begin
      if (dpolls_left > 0) begin
        bus.rnn_rdata <= {1'b0, rnd[30:0]};
        dpolls_left   <= dpolls_left - 1;
      end else begin
        bus.rnn_rdata <= {16'h8000, res_val};
      end
    end
  end

  // Transaction logs and per-cycle protocol checks.
  logic [9:0]  emb_log[$];
  logic [2:0]  wa_log[$];
  logic [31:0] wd_log[$];
  logic [2:0]  rd_log[$];
  logic        p_rd, p_wr, p_emb;
  logic [2:0]  p_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_rd = 1'b0; p_wr = 1'b0; p_emb = 1'b0; p_addr = 3'd0;
    end else begin
      if (bus.emb_rd)    emb_log.push_back(bus.emb_addr);
      if (bus.rnn_write) begin wa_log.push_back(bus.rnn_addr); wd_log.push_back(bus.rnn_wdata); end
      if (bus.rnn_read)  rd_log.push_back(bus.rnn_addr);
      total++;
      assert (!(bus.rnn_read && bus.rnn_write)) else begin
        bad++; $error("FAIL rd_wr_exclusive observed rd=%b wr=%b expected not both", bus.rnn_read, bus.rnn_write);
      end
      total++;
      assert (!(bus.rnn_read && p_rd) && !(bus.emb_rd && p_emb) &&
              !(bus.rnn_write && p_wr && bus.rnn_addr == p_addr)) else begin
        bad++; $error("FAIL strobe_width observed held strobe rd=%b emb=%b wr=%b addr=%0d expected 1-cycle", bus.rnn_read, bus.emb_rd, bus.rnn_write, bus.rnn_addr);
      end
      p_rd = bus.rnn_read; p_wr = bus.rnn_write; p_emb = bus.emb_rd; p_addr = bus.rnn_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    emb_log.delete(); wa_log.delete(); wd_log.delete(); rd_log.delete();
  endtask

  task automatic send_char(input logic [7:0] idx, input logic last);
    int n;
    n = 0;
    while (!bus.char_ready && n < BOUND) begin step(); n++; end
    chk("char_ready_wait", 32'(n < BOUND), 32'd1);
    bus.char_valid = 1'b1; bus.char_idx = idx; bus.char_last = last;
    step();
    bus.char_valid = 1'b0;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!bus.res_valid && n < BOUND) begin step(); n++; end
    chk("res_valid_wait", 32'(n < BOUND), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < BOUND) begin step(); n++; end
    chk("idle_wait", 32'(n < BOUND), 32'd1);
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("res_valid_drop", 32'(bus.res_valid), 32'd0);
    chk("idle_after_out", 32'(busy), 32'd0);
    chk("ready_after_out", 32'(bus.char_ready), 32'd1);
  endtask

  // Expected traffic: per character EMB_DIM reads/writes, a start write and
  // step_busy+1 status polls; the last character adds one dense write and polls.
  logic [7:0] seq_chars[$];

  task automatic check_logs(input string tag);
    logic [9:0]  ee[$];
    logic [2:0]  ewa[$];
    logic [31:0] ewd[$];
    logic [2:0]  erd[$];
    int mism, a;
    foreach (seq_chars[i]) begin
      for (int w = 0; w < EMB_DIM; w++) begin
        a = int'(seq_chars[i]) * EMB_DIM + w;
        ee.push_back(10'(a));
        ewa.push_back(3'd1);
        ewd.push_back((32'(w) << 16) | 32'(emb_mem[a]));
      end
      ewa.push_back(3'd0); ewd.push_back(32'd0);
      for (int k = 0; k <= step_busy; k++) erd.push_back(3'd0);
    end
    ewa.push_back(3'd7); ewd.push_back(32'd0);
    for (int k = 0; k <= dense_busy; k++) erd.push_back(3'd7);

    chk({tag, "_emb_count"}, 32'(emb_log.size()), 32'(ee.size()));
    chk({tag, "_wr_count"},  32'(wa_log.size()),  32'(ewa.size()));
    chk({tag, "_rd_count"},  32'(rd_log.size()),  32'(erd.size()));
    mism = 0;
    foreach (ee[i]) if (i < emb_log.size() && emb_log[i] !== ee[i]) mism++;
    foreach (ewa[i]) if (i < wa_log.size() && (wa_log[i] !== ewa[i] ||
                         (ewa[i] != 3'd7 && wd_log[i] !== ewd[i]))) mism++;
    foreach (erd[i]) if (i < rd_log.size() && rd_log[i] !== erd[i]) mism++;
    chk({tag, "_traffic_mismatches"}, 32'(mism), 32'd0);
  endtask

  task automatic run_seq(input string tag);
    clear_logs();
    foreach (seq_chars[i]) send_char(seq_chars[i], i == seq_chars.size() - 1);
    wait_res();
    chk({tag, "_res_data"}, 32'(bus.res_data), 32'(res_val));
    chk({tag, "_seq_len"},  32'(seq_len), 32'(seq_chars.size()));
    chk({tag, "_busy_out"}, 32'(busy), 32'd1);
    check_logs(tag);
  endtask

  int snap_e, snap_w, snap_r, n;

  initial begin
    for (int i = 0; i < 1024; i++) emb_mem[i] = 16'($urandom);
    bus.char_valid = 1'b0; bus.char_idx = '0; bus.char_last = 1'b0; bus.res_ready = 1'b0;
    bus.emb_rdata = '0; bus.rnn_rdata = '0;
    abort = 1'b0; rst_n = 1'b0; step_busy = 0; dense_busy = 0; res_val = '0;
    polls_left = 0; dpolls_left = 0;
    repeat (3) step();

    chk("rst_char_ready", 32'(bus.char_ready), 32'd0);
    chk("rst_busy",       32'(busy), 32'd0);
    chk("rst_err",        32'(err), 32'd0);
    chk("rst_seq_len",    32'(seq_len), 32'd0);
    chk("rst_res_valid",  32'(bus.res_valid), 32'd0);
    chk("rst_res_data",   32'(bus.res_data), 32'd0);
    chk("rst_strobes",    32'({bus.emb_rd, bus.rnn_read, bus.rnn_write}), 32'd0);
    chk("rst_rnn_addr",   32'(bus.rnn_addr), 32'd0);
    chk("rst_rnn_wdata",  bus.rnn_wdata, 32'd0);
    chk("rst_emb_addr",   32'(bus.emb_addr), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(bus.char_ready), 32'd1);

    // Single character, idle on first poll.
    seq_chars = '{8'd3}; step_busy = 0; dense_busy = 0; res_val = 16'h00AB;
    run_seq("single");
    consume();

    // Three steps, two busy polls each; result held while res_ready stays low.
    seq_chars = '{8'd0, 8'd1, 8'd2}; step_busy = 2; dense_busy = 1; res_val = 16'($urandom);
    run_seq("three");
    for (int c = 0; c < 10; c++) begin
      step();
      chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_res_data",  32'(bus.res_data), 32'(res_val));
      chk("hold_no_ready",  32'(bus.char_ready), 32'd0);
      chk("hold_no_strobe", 32'({bus.emb_rd, bus.rnn_read, bus.rnn_write}), 32'd0);
    end
    consume();

    // Randomized sequences.
    for (int t = 0; t < 4; t++) begin
      seq_chars.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) seq_chars.push_back(8'($urandom));
      step_busy = $urandom_range(0, POLL_MAX - 1);
      dense_busy = $urandom_range(0, POLL_MAX - 1);
      res_val = 16'($urandom);
      run_seq("rand");
      consume();
    end

    // Core never idle: exactly POLL_MAX polls then err.
    clear_logs(); step_busy = 1000;
    send_char(8'($urandom), 1'b0);
    wait_idle();
    chk("to_err",        32'(err), 32'd1);
    chk("to_poll_count", 32'(rd_log.size()), 32'(POLL_MAX));
    n = 0;
    foreach (rd_log[i]) if (rd_log[i] !== 3'd0) n++;
    chk("to_poll_addr",  32'(n), 32'd0);
    chk("to_seq_len",    32'(seq_len), 32'd0);
    step_busy = 0; dense_busy = 0; res_val = 16'($urandom);
    send_char(8'd5, 1'b1);
    chk("err_cleared",   32'(err), 32'd0);
    wait_res();
    chk("after_err_res", 32'(bus.res_data), 32'(res_val));
    consume();

    // Abort while writing embedding word 2.
    clear_logs();
    send_char(8'($urandom), 1'b1);
    n = 0;
    while (!(bus.rnn_write && bus.rnn_addr == 3'd1 && bus.rnn_wdata[31:16] == 16'd2) && n < BOUND) begin
      step(); n++;
    end
    chk("abort_reach_word2", 32'(n < BOUND), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy",    32'(busy), 32'd0);
    chk("abort_strobes", 32'({bus.emb_rd, bus.rnn_read, bus.rnn_write}), 32'd0);
    chk("abort_ready",   32'(bus.char_ready), 32'd1);
    repeat (10) step();
    chk("abort_emb_quiet", 32'(emb_log.size()), 32'd3);
    chk("abort_wr_quiet",  32'(wa_log.size()), 32'd3);
    chk("abort_rd_quiet",  32'(rd_log.size()), 32'd0);

    // Asynchronous reset in the middle of a poll.
    step_busy = 1000;
    send_char(8'($urandom), 1'b1);
    n = 0;
    while (!bus.rnn_read && n < BOUND) begin step(); n++; end
    chk("poll_reached", 32'(n < BOUND), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_read",     32'(bus.rnn_read), 32'd0);
    chk("arst_busy",     32'(busy), 32'd0);
    chk("arst_ready",    32'(bus.char_ready), 32'd0);
    chk("arst_res_data", 32'(bus.res_data), 32'd0);
    chk("arst_emb_addr", 32'(bus.emb_addr), 32'd0);
    chk("arst_rnn_addr", 32'(bus.rnn_addr), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_recover_ready", 32'(bus.char_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
